instr_fetch_sequencer: RTL



---
 rtl/instr_fetch_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/instr_fetch_sequencer.sv
`timescale 1ns/1ps
// Program RAM plus fetch/issue sequencer feeding a multicycle core.
// Handshake: Run launches one instruction for one cycle; the core answers with Done, sampled only in WAIT.
module instr_fetch_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    input  logic [ADDR_W:0]   ProgLen,
    input  logic              Start,
    input  logic              Done,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W:0]   PC,
    output logic              Busy,
    output logic              Finished,
    output logic              Fault,
    output logic [2:0]        fsm_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [2:0]        state;
    logic [ADDR_W:0]   len_q;
    logic [WD_W-1:0]   wd;
    logic [ADDR_W:0]   pc_next;

    assign pc_next = PC + 1'b1;

    // Program RAM is writable only while idle; contents survive reset.
    always_ff @(posedge Clock) begin
        if (LoadEn && state == S_IDLE) begin
            mem[LoadAddr] <= LoadData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
            PC    <= '0;
            DIN   <= '0;
            Fault <= 1'b0;
            wd    <= '0;
            len_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (ProgLen == '0) begin
                            state <= S_FIN;
                        end else begin
                            len_q <= ProgLen;
                            PC    <= '0;
                            Fault <= 1'b0;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // Synchronous read: the word lands on DIN as ISSUE begins.
                    DIN   <= mem[PC[ADDR_W-1:0]];
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (Done) begin
                        if (pc_next == len_q) begin
                            state <= S_FIN;
                        end else begin
                            PC    <= pc_next;
                            state <= S_FETCH;
                        end
                    end else if (wd == WD_LAST) begin
                        Fault <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign Run       = (state == S_ISSUE);
    assign Busy      = (state != S_IDLE);
    assign Finished  = (state == S_FIN);
    assign fsm_state = state;

endmodule
